data_plane_tx_arbiter: RTL
==========================

Name: data_plane_tx_arbiter

Overview:
Shares the single data-plane TX path (data_plane_tx) between N GPP requesters. Grants one requester at a time using round-robin order and forwards its 16-bit words onto gpp_tx_signal/gpp_tx_data. Holds the grant for a bounded burst. Waits for the downstream completion flag before re-arbitrating. Sits between the GPP cluster ports and data_plane_tx.

Parameters:
N_REQ, 4, number of requesters (2..16)
MAX_BURST, 8, max words forwarded per grant (>=1)
DRAIN_TIMEOUT, 64, cycles to wait for data_tx_flag_out before abandoning

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
req  in  N_REQ  per-requester word-valid; high = word on req_data slice is valid
req_data  in  16*N_REQ  flattened words; slice i = req_data[16*i+15:16*i]
gnt  out  N_REQ  one-hot grant, registered
gpp_tx_signal  out  1  word valid to data_plane_tx, registered
gpp_tx_data  out  16  word to data_plane_tx, registered
data_tx_flag_out  in  1  downstream packet-sent pulse/level
owner_id  out  $clog2(N_REQ)  index of current/last owner
busy  out  1  high in GRANT or DRAIN
timeout_err  out  1  one-cycle pulse on drain timeout

Behaviour:
- Reset (rst low, async): state=IDLE, gnt=0, gpp_tx_signal=0, gpp_tx_data=0, owner_id=0, busy=0, timeout_err=0, last_owner=N_REQ-1 (so requester 0 wins first), counters=0.
- States: IDLE, GRANT, DRAIN.
- IDLE:
  - If any req bit is high, pick the first requester with req high, searching last_owner+1 .. last_owner upward with wrap.
  - On the next edge: gnt[winner]=1, owner_id=winner, busy=1, word count=0, state=GRANT.
  - If no req, stay in IDLE.
  - Arbitration latency: 1 cycle from req to gnt.
- GRANT: a transfer occurs in any cycle with gnt[owner]=1 and req[owner]=1.
  - On each transfer edge: gpp_tx_signal=1, gpp_tx_data=req_data[owner], count+1.
  - In any other cycle: gpp_tx_signal=0, gpp_tx_data holds its last value.
  - Fixed latency: 1 cycle from requester to downstream.
  - Burst ends on the edge where req[owner]=0 (zero-word transfer on the first cycle is legal), or where the transfer is the MAX_BURST-th word. On that edge: gnt=0, state=DRAIN.
  - The requester sees gnt low the cycle after its last accepted word and must treat it as a stop.
  - Requests from non-owners are ignored and do not affect the outputs.
- DRAIN: gnt=0, gpp_tx_signal=0.
  - A timeout counter increments each cycle.
  - data_tx_flag_out=1: on that edge last_owner=owner_id, state=IDLE, busy=0.
  - Counter reaches DRAIN_TIMEOUT-1 without the flag: timeout_err pulses for 1 cycle, last_owner=owner_id, state=IDLE.
  - data_tx_flag_out in IDLE or GRANT is ignored.
- Fairness: an owner cannot be regranted while another requester is waiting. A sole requester is regranted, with at least one DRAIN cycle plus one IDLE cycle between bursts.
- Reset asserted mid-burst: immediate clear to the reset values; no partial word is flagged.
- Counter widths: count is $clog2(MAX_BURST+1); the timeout counter is $clog2(DRAIN_TIMEOUT+1); neither counter wraps.

Decomposition:
- Package data_plane_pkg:
  - DP_WORD_W=16.
  - arb_state_t enum {IDLE, GRANT, DRAIN}.
  - Slice helper constant for req_data indexing.
- Sub-module rr_priority_picker (parameter N): purely combinational.
  - Inputs: req vector, last index.
  - Outputs: one-hot winner, index, any_valid.
- The arbiter FSM, counters and output registers are in the top module.

Test Plan:
- Single burst: N_REQ=4, req[0] high for 5 words 0x000A,0x0005,0x0002,0x0008,0x0001, then low; flag at DRAIN cycle 2 -> gnt[0] rises 1 cycle after req; gpp_tx_signal high exactly 5 cycles carrying those words in order, 1-cycle lag; busy drops the cycle after the flag.
- Round-robin: req[0], req[2] continuously high, 2-word bursts, flag 1 cycle after DRAIN entry -> grant order 0,2,0,2; owner_id follows.
- MAX_BURST cutoff: req[1] holds 12 words, MAX_BURST=8 -> exactly 8 words forwarded, gnt[1] low after word 8; the remaining 4 words go in the next grant after the flag.
- Drain timeout: burst from req[3], flag never asserted -> timeout_err pulses at DRAIN cycle 64; state returns to IDLE; next grant goes to req[0] if pending.
- Reset mid-burst: rst low after word 2 of a 5-word burst -> all outputs 0 asynchronously; after release, first grant goes to requester 0.
- Zero-length grant: req[2] pulses for 1 cycle only -> gnt[2] for 1 cycle, no gpp_tx_signal, DRAIN entered, arbiter recovers on the flag.

Source files
------------

// File: rtl/data_plane_pkg.sv
// data_plane_pkg: shared word width, arbiter state encoding and req_data slice helper
package data_plane_pkg;
    localparam int DP_WORD_W = 16;
    typedef enum logic [1:0] {IDLE, GRANT, DRAIN} arb_state_t;
    function automatic int dp_slice_lo(input int i);
        return i * DP_WORD_W;
    endfunction
endpackage

// File: rtl/rr_priority_picker.sv
// rr_priority_picker: combinational round-robin search starting just above last, wrapping
module rr_priority_picker #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [N-1:0]  winner,
    output logic [IW-1:0] index,
    output logic          any_valid
);
    logic          found;
    logic [IW-1:0] j;
    always_comb begin
        index = '0;
        found = 1'b0;
        j     = '0;
        for (int k = 1; k <= N; k++) begin
            j = IW'((int'(last) + k) % N);
            if (!found && req[j]) begin
                found = 1'b1;
                index = j;
            end
        end
    end
    assign any_valid = |req;
    assign winner    = any_valid ? N'(1) << index : '0;
endmodule

// File: rtl/data_plane_tx_arbiter.sv
// data_plane_tx_arbiter: round-robin owner of the data-plane TX path with bounded bursts
// and a drain phase that waits for the downstream sent flag (or a timeout).
module data_plane_tx_arbiter
    import data_plane_pkg::*;
#(
    parameter int N_REQ         = 4,
    parameter int MAX_BURST     = 8,
    parameter int DRAIN_TIMEOUT = 64,
    parameter int IW            = $clog2(N_REQ)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N_REQ-1:0]             req,
    input  logic [DP_WORD_W*N_REQ-1:0]   req_data,
    output logic [N_REQ-1:0]             gnt,
    output logic                         gpp_tx_signal,
    output logic [DP_WORD_W-1:0]         gpp_tx_data,
    input  logic                         data_tx_flag_out,
    output logic [IW-1:0]                owner_id,
    output logic                         busy,
    output logic                         timeout_err
);
    localparam int CW = $clog2(MAX_BURST + 1);
    localparam int TW = $clog2(DRAIN_TIMEOUT + 1);

    arb_state_t           state;
    logic [IW-1:0]        last_owner;
    logic [CW-1:0]        count;
    logic [TW-1:0]        tmo;
    logic [N_REQ-1:0]     pick_onehot;
    logic [IW-1:0]        pick_idx;
    logic                 any_req;
    logic [DP_WORD_W-1:0] words [N_REQ];

    for (genvar i = 0; i < N_REQ; i++) begin : g_slice
        assign words[i] = req_data[dp_slice_lo(i) +: DP_WORD_W];
    end

    rr_priority_picker #(.N(N_REQ), .IW(IW)) u_pick (
        .req       (req),
        .last      (last_owner),
        .winner    (pick_onehot),
        .index     (pick_idx),
        .any_valid (any_req)
    );

    logic owner_req;
    assign owner_req = req[owner_id];
    assign busy      = state != IDLE;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            gnt           <= '0;
            gpp_tx_signal <= 1'b0;
            gpp_tx_data   <= '0;
            owner_id      <= '0;
            timeout_err   <= 1'b0;
            last_owner    <= IW'(N_REQ - 1);
            count         <= '0;
            tmo           <= '0;
        end else begin
            timeout_err   <= 1'b0;
            gpp_tx_signal <= 1'b0;
            case (state)
                IDLE: if (any_req) begin
                    gnt      <= pick_onehot;
                    owner_id <= pick_idx;
                    count    <= '0;
                    state    <= GRANT;
                end
                GRANT: begin
                    if (owner_req) begin
                        gpp_tx_signal <= 1'b1;
                        gpp_tx_data   <= words[owner_id];
                        count         <= count + 1'b1;
                    end
                    // a dropped request or the last allowed word closes the burst
                    if (!owner_req || count == CW'(MAX_BURST - 1)) begin
                        gnt   <= '0;
                        tmo   <= '0;
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    tmo <= tmo + 1'b1;
                    if (data_tx_flag_out) begin
                        last_owner <= owner_id;
                        state      <= IDLE;
                    end else if (tmo == TW'(DRAIN_TIMEOUT - 1)) begin
                        timeout_err <= 1'b1;
                        last_owner  <= owner_id;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
